// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, then resets and runs the CPU under a cycle budget.
// Define LOADER_CSUM_EN to add the prog_csum running checksum output.
module prog_loader #(
  parameter int INSTR_W = 9,
  parameter int DEPTH = 256,
  parameter int MAX_CYCLES = 1024,
  parameter int RST_CYCLES = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               start,
  input  logic               clear,
  input  logic               cpu_done,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               cpu_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               load_err,
  output logic [ADDR_W:0]    words_loaded,
  output logic [31:0]        cycle_count
`ifdef LOADER_CSUM_EN
  ,
  output logic [INSTR_W-1:0] prog_csum
`endif
);
  typedef enum logic [2:0] {LOAD, READY, RST_HOLD, RUN, DONE} state_t;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] FULL_M1 = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);
  localparam logic [31:0] LAST_HOLD = 32'(RST_CYCLES - 1);
  state_t state, state_n;
  logic accept, start_run;
  logic [31:0] hold_cnt;
  assign load_ready = state == LOAD && words_loaded < FULL;
  assign accept = load_valid && load_ready && !clear;
  assign start_run = start && !clear && (state == READY || state == DONE);
  assign cpu_reset = state == LOAD || state == READY || state == RST_HOLD;
  assign cpu_en = state == RST_HOLD || state == RUN;
  assign busy = cpu_en;
  always_comb begin
    state_n = state;
    if (clear) state_n = LOAD;
    else
      case (state)
        LOAD:     if (accept && (load_last || words_loaded == FULL_M1)) state_n = READY;
        READY:    if (start) state_n = RST_HOLD;
        RST_HOLD: if (hold_cnt == LAST_HOLD) state_n = RUN;
        RUN:      if (cpu_done || cycle_count == LAST_CYCLE) state_n = DONE;
        DONE:     if (start) state_n = RST_HOLD;
        default:  state_n = LOAD;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
      load_err <= 1'b0;
      words_loaded <= '0;
      cycle_count <= '0;
      hold_cnt <= '0;
    end else if (clear) begin
      imem_we <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      load_err <= 1'b0;
      words_loaded <= '0;
      cycle_count <= '0;
      hold_cnt <= '0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_addr <= words_loaded[ADDR_W-1:0];
        imem_wdata <= load_data;
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
        if (!load_last && words_loaded == FULL_M1) load_err <= 1'b1;
      end
      if (start_run) begin
        done <= 1'b0;
        timeout <= 1'b0;
        cycle_count <= '0;
        hold_cnt <= '0;
      end
      if (state == RST_HOLD) hold_cnt <= hold_cnt + 32'd1;
      if (state == RUN) begin
        cycle_count <= (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
        // cpu_done takes priority over a budget expiring on the same edge
        if (cpu_done) done <= 1'b1;
        else if (cycle_count == LAST_CYCLE) timeout <= 1'b1;
      end
    end
  end
`ifdef LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset || clear) prog_csum <= '0;
    else if (accept) prog_csum <= prog_csum ^ {load_data[INSTR_W-2:0], load_data[INSTR_W-1]};
  end
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized load/run/clear scenarios checked against a transaction-level model.
module tb_prog_loader;
  localparam int W = 9;
  localparam int D = 4;
  localparam int MC = 16;
  localparam int RC = 2;
  localparam int AW = $clog2(D);
  logic clk = 1'b0;
  logic reset, load_valid, load_last, start, clear, cpu_done;
  logic [W-1:0] load_data;
  logic load_ready, imem_we, cpu_reset, cpu_en, busy, done, timeout, load_err;
  logic [AW-1:0] imem_addr;
  logic [W-1:0] imem_wdata;
  logic [AW:0] words_loaded;
  logic [31:0] cycle_count;
`ifdef LOADER_CSUM_EN
  logic [W-1:0] prog_csum;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [AW-1:0] wa[$];
  logic [W-1:0] wd[$];
  logic [W-1:0] w[8];
  always #5 clk = ~clk;
  prog_loader #(.INSTR_W(W), .DEPTH(D), .MAX_CYCLES(MC), .RST_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .clear(clear),
    .cpu_done(cpu_done), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .busy(busy), .done(done), .timeout(timeout),
    .load_err(load_err), .words_loaded(words_loaded), .cycle_count(cycle_count)
`ifdef LOADER_CSUM_EN
    , .prog_csum(prog_csum)
`endif
  );
  always @(negedge clk) if (imem_we) begin
    wa.push_back(imem_addr);
    wd.push_back(imem_wdata);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_outs"}, {load_ready, imem_we, cpu_reset, cpu_en, busy, done, timeout, load_err}, 8'b10100000);
    check({tag, "_words"}, words_loaded, 0);
    check({tag, "_cnt"}, cycle_count, 0);
`ifdef LOADER_CSUM_EN
    check({tag, "_csum"}, prog_csum, 0);
`endif
  endtask
  task automatic load_prog(input int n, input int lastpos, input logic [7:0] gaps);
    int acc;
    logic err;
    logic [W-1:0] csum;
    acc = (lastpos < n && lastpos < D) ? lastpos + 1 : D;
    err = !(lastpos < n && lastpos < D);
    csum = '0;
    wa.delete();
    wd.delete();
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) begin
        load_valid = 1'b0;
        tick();
      end
      check("load_ready", load_ready, i < acc);
      load_valid = 1'b1;
      load_data = w[i];
      load_last = (i == lastpos);
      tick();
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    tick();
    check("n_writes", wa.size(), acc);
    for (int i = 0; i < acc && i < wa.size(); i++) begin
      check("waddr", wa[i], i);
      check("wdata", wd[i], w[i]);
      csum ^= {w[i][W-2:0], w[i][W-1]};
    end
    check("words_loaded", words_loaded, acc);
    check("load_err", load_err, err);
    check("ready_state", {load_ready, cpu_reset, cpu_en, busy}, 4'b0100);
`ifdef LOADER_CSUM_EN
    check("prog_csum", prog_csum, csum);
`endif
  endtask
  // k = RUN cycle on which cpu_done rises; beyond the budget means never
  task automatic run_prog(input int k);
    int hold, runc, expc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_flags", {done, timeout}, 0);
    check("start_cnt", cycle_count, 0);
    hold = 0;
    runc = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      if (cpu_reset && cpu_en) hold++;
      if (!cpu_reset && cpu_en) runc++;
      cpu_done = (runc == 0) ? 1'($urandom_range(0, 1)) : (runc == k);
      tick();
    end
    cpu_done = 1'b0;
    expc = (k <= MC) ? k : MC;
    check("run_end", busy, 0);
    check("hold_cycles", hold, RC);
    check("run_cycles", runc, expc);
    check("cycle_count", cycle_count, expc);
    check("done", done, k <= MC);
    check("timeout", timeout, k > MC);
    check("frozen", {cpu_reset, cpu_en}, 0);
    repeat (3) begin
      cpu_done = 1'($urandom_range(0, 1));
      tick();
    end
    cpu_done = 1'b0;
    check("sticky", {done, timeout, cycle_count}, {k <= MC, k > MC, 32'(expc)});
  endtask
  // clear with a competing start and load beat: clear must win
  task automatic do_clear;
    wa.delete();
    wd.delete();
    clear = 1'b1;
    start = 1'b1;
    load_valid = 1'b1;
    load_last = 1'b1;
    load_data = 9'h1A5;
    tick();
    clear = 1'b0;
    start = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    check_idle("clear");
    tick();
    check("clear_nowrite", wa.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int runc, n, lp;
    reset = 1'b1;
    {load_valid, load_last, start, clear, cpu_done} = '0;
    load_data = '0;
    tick();
    tick();
    reset = 1'b0;
    check_idle("rst");
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    w[0] = 9'h001; w[1] = 9'h054; w[2] = 9'h0BB; w[3] = 9'h16E;
    load_prog(4, 3, 8'h00);
    run_prog(10);
    do_clear();
    load_prog(4, 3, 8'b0000_1010);
    run_prog(99);
    run_prog(16);
    run_prog(15);
    do_clear();
    for (int i = 0; i < 8; i++) w[i] = W'($urandom);
    load_prog(5, 5, 8'h00);
    do_clear();
    do_clear();
    load_prog(3, 2, 8'h04);
    start = 1'b1;
    tick();
    start = 1'b0;
    runc = 0;
    for (int c = 0; c < 50; c++) begin
      if (!cpu_reset && cpu_en) runc++;
      if (runc == 5) break;
      tick();
    end
    check("mid_run", runc, 5);
    check("mid_cnt", cycle_count, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_addr", imem_addr, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_load", {load_ready, cpu_reset, busy}, 3'b110);
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 8; i++) w[i] = W'($urandom);
      n = $urandom_range(1, 6);
      lp = $urandom_range(0, n);
      if (lp == n && n < D) lp = n - 1;
      load_prog(n, lp, 8'($urandom));
      run_prog($urandom_range(1, 20));
      do_clear();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
